// File: rtl/clock_multiplier_controller.sv
// clock_multiplier_controller
//
// On/off sequencer for a shared multiplied-clock resource: a clock multiplier
// (DLL/PLL) followed by a clock gate. Requests from any consumer power the
// multiplier up, wait a fixed lock time, then open the gate. After an idle
// timeout with no requests the gate closes and the multiplier is disabled
// one cycle later. Grants are only issued while the gate is open.
//
// Ports:
//   clock              reference clock, rising edge
//   resetn             asynchronous active-low reset
//   requests           level request per requester, synchronous to clock
//   grants             registered grant per requester (requests & open gate)
//   multiplier_enable  enable to the multiplier
//   clock_gate_enable  enable to the clock gate on the multiplied clock
//   busy               high whenever the sequencer is not DISABLED
module clock_multiplier_controller #(
    parameter int REQUESTERS  = 4,
    parameter int LOCK_CYCLES = 16,
    parameter int IDLE_CYCLES = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic [REQUESTERS-1:0] requests,
    output logic [REQUESTERS-1:0] grants,
    output logic                  multiplier_enable,
    output logic                  clock_gate_enable,
    output logic                  busy
);

    localparam int MAX_CYCLES = (LOCK_CYCLES > IDLE_CYCLES) ? LOCK_CYCLES : IDLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_LOCKING,
        ST_ACTIVE,
        ST_IDLE,
        ST_STOPPING
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             any_request;

    assign any_request = |requests;
    assign busy        = (state != ST_DISABLED);

    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            ST_DISABLED: begin
                if (any_request) begin
                    state_next = ST_LOCKING;
                    count_next = LOCK_LOAD;
                end
            end
            // Requests are ignored while locking; an aborted request still
            // completes the lock and then times out through IDLE.
            ST_LOCKING: begin
                if (count <= CNT_ONE) begin
                    state_next = ST_ACTIVE;
                    count_next = '0;
                end else begin
                    count_next = count - CNT_ONE;
                end
            end
            ST_ACTIVE: begin
                if (!any_request) begin
                    state_next = ST_IDLE;
                    count_next = IDLE_LOAD;
                end
            end
            // A request on the expiry cycle takes priority over shutdown.
            ST_IDLE: begin
                if (any_request) begin
                    state_next = ST_ACTIVE;
                end else if (count <= CNT_ONE) begin
                    state_next = ST_STOPPING;
                    count_next = '0;
                end else begin
                    count_next = count - CNT_ONE;
                end
            end
            ST_STOPPING: begin
                state_next = ST_DISABLED;
            end
            default: begin
                state_next = ST_DISABLED;
                count_next = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state itself. Grants use the registered gate value, which
    // keeps the gate open at least one cycle ahead of any grant.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state             <= ST_DISABLED;
            count             <= '0;
            multiplier_enable <= 1'b0;
            clock_gate_enable <= 1'b0;
            grants            <= '0;
        end else begin
            state             <= state_next;
            count             <= count_next;
            multiplier_enable <= (state_next != ST_DISABLED);
            clock_gate_enable <= (state_next == ST_ACTIVE) || (state_next == ST_IDLE);
            grants            <= requests & {REQUESTERS{clock_gate_enable}};
        end
    end

endmodule

// File: tb/tb_clock_multiplier_controller.sv
module tb_clock_multiplier_controller;

    localparam int REQ  = 4;
    localparam int LOCK = 16;
    localparam int IDLE = 8;

    logic           clock;
    logic           resetn;
    logic [REQ-1:0] requests;
    logic [REQ-1:0] grants;
    logic           multiplier_enable;
    logic           clock_gate_enable;
    logic           busy;

    clock_multiplier_controller #(
        .REQUESTERS (REQ),
        .LOCK_CYCLES(LOCK),
        .IDLE_CYCLES(IDLE)
    ) dut (
        .clock            (clock),
        .resetn           (resetn),
        .requests         (requests),
        .grants           (grants),
        .multiplier_enable(multiplier_enable),
        .clock_gate_enable(clock_gate_enable),
        .busy             (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [REQ-1:0] grants;
        logic           en;
        logic           gate;
        logic           busy;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, $signed(got), $signed(exp), $time);
        end
    endtask

    // Reference model: phase plus up-counting cycles spent in that phase.
    // Phases: 0 off, 1 locking, 2 active, 3 idle, 4 stopping.
    int   m_phase   = 0;
    int   m_elapsed = 0;
    logic m_gate    = 1'b0;

    task automatic model_reset();
        m_phase   = 0;
        m_elapsed = 0;
        m_gate    = 1'b0;
    endtask

    task automatic model_edge(input logic [REQ-1:0] r, output exp_t e);
        logic any;
        any      = (r != '0);
        e.grants = m_gate ? r : '0;
        case (m_phase)
            0: if (any) begin m_phase = 1; m_elapsed = 0; end
            1: begin
                m_elapsed++;
                if (m_elapsed == LOCK) m_phase = 2;
            end
            2: if (!any) begin m_phase = 3; m_elapsed = 0; end
            3: begin
                if (any) m_phase = 2;
                else begin
                    m_elapsed++;
                    if (m_elapsed == IDLE) m_phase = 4;
                end
            end
            default: m_phase = 0;
        endcase
        m_gate = (m_phase == 2) || (m_phase == 3);
        e.gate = m_gate;
        e.en   = (m_phase != 0);
        e.busy = (m_phase != 0);
    endtask

    // Edge bookkeeping for explicit timing checks against spec latencies.
    int   edge_n = 0;
    int   en_rise, en_fall, gate_rise, gate_fall, grant_rise;
    logic prev_en, prev_gate;
    logic [REQ-1:0] prev_grants;

    task automatic clear_marks();
        en_rise    = -1;
        en_fall    = -1;
        gate_rise  = -1;
        gate_fall  = -1;
        grant_rise = -1;
    endtask

    task automatic step(input logic [REQ-1:0] r);
        exp_t e;
        exp_t got;
        int   cur;
        requests = r;
        model_edge(r, e);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        cur = edge_n;
        edge_n++;
        if (exp_q.size() == 0) begin
            check("scoreboard_underflow", 1, 0);
        end else begin
            got = exp_q.pop_front();
            check("grants", {28'd0, grants}, {28'd0, got.grants});
            check("multiplier_enable", {31'd0, multiplier_enable}, {31'd0, got.en});
            check("clock_gate_enable", {31'd0, clock_gate_enable}, {31'd0, got.gate});
            check("busy", {31'd0, busy}, {31'd0, got.busy});
        end
        if (!prev_en && multiplier_enable) en_rise = cur;
        if (prev_en && !multiplier_enable) en_fall = cur;
        if (!prev_gate && clock_gate_enable) gate_rise = cur;
        if (prev_gate && !clock_gate_enable) gate_fall = cur;
        if (prev_grants == '0 && grants != '0) grant_rise = cur;
        prev_en     = multiplier_enable;
        prev_gate   = clock_gate_enable;
        prev_grants = grants;
    endtask

    // Asserts reset mid-cycle, checks the outputs clear without a clock edge,
    // and releases reset before the next rising edge.
    task automatic mid_reset(input string tag);
        #2;
        resetn = 1'b0;
        #1;
        check({tag, "_grants"}, {28'd0, grants}, 32'd0);
        check({tag, "_enable"}, {31'd0, multiplier_enable}, 32'd0);
        check({tag, "_gate"}, {31'd0, clock_gate_enable}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        #2;
        resetn = 1'b1;
        model_reset();
        exp_q.delete();
        prev_en     = 1'b0;
        prev_gate   = 1'b0;
        prev_grants = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        int f0;
        int s0;
        int en_fall_before;

        requests    = '0;
        resetn      = 1'b0;
        prev_en     = 1'b0;
        prev_gate   = 1'b0;
        prev_grants = '0;
        clear_marks();
        repeat (2) @(posedge clock);
        #1;
        check("reset_grants", {28'd0, grants}, 32'd0);
        check("reset_enable", {31'd0, multiplier_enable}, 32'd0);
        check("reset_gate", {31'd0, clock_gate_enable}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        resetn = 1'b1;
        model_reset();

        // Startup with defaults.
        clear_marks();
        e0 = edge_n;
        repeat (20) step(4'b0001);
        check("startup_en_edge", en_rise - e0, 0);
        check("startup_gate_edge", gate_rise - e0, LOCK);
        check("startup_grant_edge", grant_rise - e0, LOCK + 1);

        // Overlapping requesters, then requester 0 drops while 3 stays.
        repeat (3) step(4'b1001);
        repeat (4) step(4'b1000);
        repeat (2) step(4'b0110);

        // Idle shutdown.
        clear_marks();
        f0 = edge_n;
        repeat (12) step(4'b0000);
        check("shutdown_gate_edge", gate_fall - f0, IDLE);
        check("shutdown_en_edge", en_fall - f0, IDLE + 1);

        // Restart, then idle rescue on the expiry cycle.
        repeat (18) step(4'b0001);
        clear_marks();
        f0 = edge_n;
        repeat (IDLE) step(4'b0000);
        step(4'b0100);
        repeat (3) step(4'b0100);
        check("rescue_no_gate_fall", gate_fall, -1);
        check("rescue_no_en_fall", en_fall, -1);
        check("rescue_grant_edge", grant_rise - f0, IDLE);

        // Single-cycle pulse from DISABLED.
        repeat (12) step(4'b0000);
        clear_marks();
        e0 = edge_n;
        step(4'b0001);
        repeat (30) step(4'b0000);
        check("pulse_gate_edge", gate_rise - e0, LOCK);
        check("pulse_no_grant", grant_rise, -1);
        check("pulse_en_fall_edge", en_fall - e0, LOCK + 1 + IDLE + 1);

        // Request first sampled on the STOPPING edge: full relock.
        repeat (18) step(4'b0001);
        clear_marks();
        repeat (IDLE + 1) step(4'b0000);
        s0 = edge_n;
        en_fall_before = -1;
        repeat (20) step(4'b0001);
        check("stopping_en_fall", en_fall - s0, 0);
        check("stopping_en_rise", en_rise - s0, 1);
        check("stopping_gate_edge", gate_rise - s0, 1 + LOCK);
        check("stopping_en_fall_tracked", en_fall_before, -1);

        // Reset while ACTIVE, then full startup with the request held.
        mid_reset("rst_active");
        clear_marks();
        e0 = edge_n;
        repeat (5) step(4'b0010);
        check("rst_active_restart_en", en_rise - e0, 0);

        // Reset while LOCKING, then full startup.
        mid_reset("rst_locking");
        clear_marks();
        e0 = edge_n;
        repeat (20) step(4'b0010);
        check("rst_lock_gate_edge", gate_rise - e0, LOCK);
        check("rst_lock_grant_edge", grant_rise - e0, LOCK + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
